// File: rtl/cam_pkt_pkg.sv
// Shared state encodings, framing words and header helpers for the camera
// line packetizer.
package cam_pkt_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_HEADER  = 3'd1;
   localparam logic [2:0] ST_PAYLOAD = 3'd2;
   localparam logic [2:0] ST_PAD     = 3'd3;
   localparam logic [2:0] ST_TERM    = 3'd4;

   localparam int         HDR_BYTES  = 20;
   localparam int         MARKER     = 8;
   localparam logic [8:0] TERM_WORD  = 9'h000;
   localparam logic [8:0] PAD_WORD   = 9'h100;

   function automatic logic [8:0] data_word(input logic [7:0] b);
      logic [8:0] w;
      w         = {1'b0, b};
      w[MARKER] = 1'b1;
      return w;
   endfunction

   // The header is one 160-bit big-endian record; byte idx is shifted to the top.
   function automatic logic [7:0] hdr_byte(input logic [4:0]  idx,
                                           input logic [47:0] dst,
                                           input logic [47:0] src,
                                           input logic [15:0] etype,
                                           input logic [15:0] frame,
                                           input logic [15:0] line,
                                           input logic [15:0] len);
      logic [159:0] rec;
      rec = {dst, src, etype, frame, line, len};
      rec = rec << {idx, 3'b000};
      return rec[159:152];
   endfunction

endpackage

// File: rtl/cam_line_ram.sv
// Single-clock simple dual-port line buffer with a registered read port.
module cam_line_ram
   import cam_pkt_pkg::*;
#(
   parameter int DEPTH = 800,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          reset_b,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_r [DEPTH];
   logic [7:0] rdata_r;

   // Write port; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Synchronous read: data for raddr appears the cycle after it is presented.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rdata_r <= 8'h00;
      end else begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/cam_line_packetizer.sv
// Captures one href-qualified camera line and replays it as a marked Ethernet
// frame image on a 9-bit FIFO write stream, closed by a terminator word.
module cam_line_packetizer
   import cam_pkt_pkg::*;
#(
   parameter int          MAX_LINE    = 800,
   parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
   parameter logic [47:0] SRC_MAC     = 48'h0002_0304_0506,
   parameter logic [15:0] ETHERTYPE   = 16'h88B5,
   parameter int          MIN_PAYLOAD = 40
) (
   input  logic        clk,
   input  logic        reset_b,
   input  logic [7:0]  cam_data,
   input  logic        cam_href,
   input  logic        cam_vsync,
   input  logic        go,
   output logic [8:0]  out_data,
   output logic        out_valid,
   output logic [15:0] frame_num,
   output logic [7:0]  drop_count
);

   localparam int            AW       = $clog2(MAX_LINE);
   localparam int            PW       = $clog2(MAX_LINE + 1);
   localparam logic [PW-1:0] MAX_PTR  = PW'(MAX_LINE);
   localparam logic [15:0]   MIN_LEN  = 16'(MIN_PAYLOAD);
   localparam logic [15:0]   HDR_LAST = 16'(HDR_BYTES - 1);

   logic          href_q_r, vsync_q_r, armed_r, drop_line_r, out_valid_r;
   logic [15:0]   frame_num_r, line_num_r, len_r, pkt_frame_r, pkt_line_r, cnt_r;
   logic [7:0]    drop_count_r;
   logic [PW-1:0] wr_ptr_r;
   logic [2:0]    state_r;
   logic [8:0]    out_word_r;

   logic          href_rise_s, href_fall_s, vsync_rise_s, busy_s;
   logic          line_drop_s, wr_en_s, start_s;
   logic [15:0]   pad_len_s;
   logic [AW-1:0] rd_addr_s;
   logic [7:0]    rd_data_s;

   assign href_rise_s  = cam_href & ~href_q_r;
   assign href_fall_s  = ~cam_href & href_q_r;
   assign vsync_rise_s = cam_vsync & ~vsync_q_r;
   assign busy_s       = (state_r != ST_IDLE);
   // A line that starts while the emitter is busy stays dropped until href falls.
   assign line_drop_s  = href_rise_s ? busy_s : drop_line_r;
   assign wr_en_s      = armed_r & ~busy_s & cam_href & ~line_drop_s & (wr_ptr_r < MAX_PTR);
   assign start_s      = href_fall_s & ~busy_s & (wr_ptr_r != {PW{1'b0}});

   // Pad count and read address (byte i+1 is fetched while byte i is on the bus).
   always_comb begin
      pad_len_s = 16'd0;
      rd_addr_s = {AW{1'b0}};
      if (len_r < MIN_LEN) begin
         pad_len_s = MIN_LEN - len_r;
      end else begin
         pad_len_s = 16'd0;
      end
      if ((state_r == ST_PAYLOAD) && ((cnt_r + 16'd1) < len_r)) begin
         rd_addr_s = AW'(cnt_r + 16'd1);
      end else begin
         rd_addr_s = {AW{1'b0}};
      end
   end

   cam_line_ram #(.DEPTH(MAX_LINE), .AW(AW)) u_ram (
      .clk     (clk),
      .reset_b (reset_b),
      .we      (wr_en_s),
      .waddr   (wr_ptr_r[AW-1:0]),
      .wdata   (cam_data),
      .raddr   (rd_addr_s),
      .rdata   (rd_data_s)
   );

   // Input edge history, frame/line counters, drop accounting and capture pointer.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         href_q_r     <= 1'b0;
         vsync_q_r    <= 1'b0;
         armed_r      <= 1'b0;
         drop_line_r  <= 1'b0;
         frame_num_r  <= 16'd0;
         line_num_r   <= 16'd0;
         drop_count_r <= 8'd0;
         wr_ptr_r     <= {PW{1'b0}};
      end else begin
         href_q_r    <= cam_href;
         vsync_q_r   <= cam_vsync;
         drop_line_r <= line_drop_s;
         if (vsync_rise_s) begin
            armed_r     <= go;
            frame_num_r <= frame_num_r + 16'd1;
            line_num_r  <= 16'd0;
         end else if (href_fall_s) begin
            line_num_r  <= line_num_r + 16'd1;
         end
         if (href_rise_s && busy_s && (drop_count_r != 8'hFF)) begin
            drop_count_r <= drop_count_r + 8'd1;
         end
         if (href_fall_s) begin
            wr_ptr_r <= {PW{1'b0}};
         end else if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1'b1);
         end
      end
   end

   // Emitter: out_word_r/out_valid_r always describe the word on the bus this cycle.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 16'd0;
         len_r       <= 16'd0;
         pkt_frame_r <= 16'd0;
         pkt_line_r  <= 16'd0;
         out_word_r  <= TERM_WORD;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_s) begin
                  state_r     <= ST_HEADER;
                  cnt_r       <= 16'd0;
                  len_r       <= 16'(wr_ptr_r);
                  pkt_frame_r <= frame_num_r;
                  pkt_line_r  <= line_num_r;
                  out_word_r  <= data_word(DST_MAC[47:40]);
                  out_valid_r <= 1'b1;
               end else begin
                  out_word_r  <= TERM_WORD;
                  out_valid_r <= 1'b0;
               end
            end
            ST_HEADER: begin
               if (cnt_r == HDR_LAST) begin
                  state_r    <= ST_PAYLOAD;
                  cnt_r      <= 16'd0;
                  out_word_r <= TERM_WORD;
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  out_word_r <= data_word(hdr_byte(5'(cnt_r + 16'd1), DST_MAC, SRC_MAC,
                                                   ETHERTYPE, pkt_frame_r, pkt_line_r, len_r));
               end
            end
            ST_PAYLOAD: begin
               if (cnt_r == (len_r - 16'd1)) begin
                  cnt_r <= 16'd0;
                  if (pad_len_s != 16'd0) begin
                     state_r    <= ST_PAD;
                     out_word_r <= PAD_WORD;
                  end else begin
                     state_r    <= ST_TERM;
                     out_word_r <= TERM_WORD;
                  end
               end else begin
                  cnt_r <= cnt_r + 16'd1;
               end
            end
            ST_PAD: begin
               if (cnt_r == (pad_len_s - 16'd1)) begin
                  state_r    <= ST_TERM;
                  out_word_r <= TERM_WORD;
               end else begin
                  cnt_r      <= cnt_r + 16'd1;
                  out_word_r <= PAD_WORD;
               end
            end
            ST_TERM: begin
               state_r     <= ST_IDLE;
               out_word_r  <= TERM_WORD;
               out_valid_r <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_word_r  <= TERM_WORD;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out_data   = (state_r == ST_PAYLOAD) ? data_word(rd_data_s) : out_word_r;
   assign out_valid  = out_valid_r;
   assign frame_num  = frame_num_r;
   assign drop_count = drop_count_r;

endmodule

// File: tb/tb_cam_line_packetizer.sv
// Directed-sequence bench with randomized line contents, checked against a
// packet-level reference model of the expected FIFO word stream.
module tb_cam_line_packetizer;

   localparam int          MAX_LINE    = 800;
   localparam int          MIN_PAYLOAD = 40;
   localparam logic [47:0] DST         = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] SRC         = 48'h0002_0304_0506;
   localparam logic [15:0] ETYPE       = 16'h88B5;

   logic        clk = 1'b0;
   logic        reset_b;
   logic [7:0]  cam_data;
   logic        cam_href, cam_vsync, go;
   logic [8:0]  out_data;
   logic        out_valid;
   logic [15:0] frame_num;
   logic [7:0]  drop_count;

   cam_line_packetizer dut (
      .clk        (clk),
      .reset_b    (reset_b),
      .cam_data   (cam_data),
      .cam_href   (cam_href),
      .cam_vsync  (cam_vsync),
      .go         (go),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .frame_num  (frame_num),
      .drop_count (drop_count)
   );

   always #12 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [8:0] obs_w[$];
   int         obs_c[$];
   logic [8:0] exp_w[$];
   int         exp_c[$];

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         obs_w.push_back(out_data);
         obs_c.push_back(cyc);
      end
   end

   int          checks = 0;
   int          failures = 0;
   logic [15:0] m_frame, m_line;
   bit          m_armed;
   int          m_drops;
   int          last_fall = -100000;
   int          last_len = 0;
   logic [7:0]  pat[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic fill_random(input int n);
      pat.delete();
      for (int i = 0; i < n; i++) pat.push_back(8'($urandom));
   endtask

   // Expected packet: header fields, captured bytes, zero padding, terminator.
   task automatic model_packet(input int fall_cyc);
      logic [8:0]  pk[$];
      int          len;
      logic [15:0] len16;
      len   = (pat.size() > MAX_LINE) ? MAX_LINE : pat.size();
      len16 = 16'(len);
      for (int i = 5; i >= 0; i--) pk.push_back({1'b1, 8'(DST >> (8 * i))});
      for (int i = 5; i >= 0; i--) pk.push_back({1'b1, 8'(SRC >> (8 * i))});
      pk.push_back({1'b1, ETYPE[15:8]});
      pk.push_back({1'b1, ETYPE[7:0]});
      pk.push_back({1'b1, m_frame[15:8]});
      pk.push_back({1'b1, m_frame[7:0]});
      pk.push_back({1'b1, m_line[15:8]});
      pk.push_back({1'b1, m_line[7:0]});
      pk.push_back({1'b1, len16[15:8]});
      pk.push_back({1'b1, len16[7:0]});
      for (int i = 0; i < len; i++) pk.push_back({1'b1, pat[i]});
      for (int i = len; i < MIN_PAYLOAD; i++) pk.push_back(9'h100);
      pk.push_back(9'h000);
      foreach (pk[i]) begin
         exp_w.push_back(pk[i]);
         exp_c.push_back(fall_cyc + 1 + i);
      end
      last_fall = fall_cyc;
      last_len  = pk.size();
   endtask

   // Plays pat as one line after gap idle cycles; optionally raises vsync at the fall.
   task automatic drive_line(input int gap, input bit vs_at_fall, input logic vs_go);
      bit dropped;
      int m, nf;
      cam_href  = 1'b0;
      cam_vsync = 1'b0;
      repeat (gap) tick();
      m       = cyc;
      dropped = (last_len > 0) && (m >= last_fall + 1) && (m <= last_fall + last_len);
      foreach (pat[i]) begin
         cam_href = 1'b1;
         cam_data = pat[i];
         tick();
      end
      cam_href = 1'b0;
      cam_data = 8'h00;
      nf       = cyc;
      if (vs_at_fall) begin
         go        = vs_go;
         cam_vsync = 1'b1;
      end
      if (dropped) m_drops = (m_drops >= 255) ? 255 : m_drops + 1;
      if (m_armed && !dropped && pat.size() > 0) model_packet(nf);
      m_line = m_line + 16'd1;
      if (vs_at_fall) begin
         m_frame = m_frame + 16'd1;
         m_line  = 16'd0;
         m_armed = vs_go;
      end
   endtask

   task automatic do_vsync(input logic g);
      cam_vsync = 1'b0;
      tick();
      go        = g;
      cam_vsync = 1'b1;
      tick();
      m_frame   = m_frame + 16'd1;
      m_line    = 16'd0;
      m_armed   = g;
      cam_vsync = 1'b0;
      tick();
   endtask

   task automatic wait_drain(input string tag);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if ((cyc > last_fall + last_len) && (out_valid === 1'b0)) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, "_drain"}, 64'(ok), 64'd1);
   endtask

   task automatic check_stream(input string tag);
      int n;
      chk({tag, "_words"}, 64'(obs_w.size()), 64'(exp_w.size()));
      n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_cyc_word"}, 64'({32'(obs_c[i]), obs_w[i]}), 64'({32'(exp_c[i]), exp_w[i]}));
      end
      obs_w.delete(); obs_c.delete(); exp_w.delete(); exp_c.delete();
   endtask

   initial begin
      int g;
      reset_b = 1'b0; cam_data = 8'h00; cam_href = 1'b0; cam_vsync = 1'b0; go = 1'b0;
      m_frame = 16'd0; m_line = 16'd0; m_armed = 1'b0; m_drops = 0;
      repeat (3) tick();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_frame", 64'(frame_num), 64'd0);
      chk("rst_drop", 64'(drop_count), 64'd0);
      reset_b = 1'b1;
      tick();

      // Basic short line with padding
      do_vsync(1'b1);
      pat = {8'h11, 8'h22, 8'h33, 8'h44};
      drive_line(3, 1'b0, 1'b0);
      wait_drain("t1");
      chk("t1_len61", 64'(obs_w.size()), 64'd61);
      check_stream("t1");
      chk("t1_frame", 64'(frame_num), 64'(m_frame));

      // Random lines; go toggles mid-frame without effect
      for (int t = 0; t < 6; t++) begin
         fill_random(int'($urandom_range(1, 120)));
         go = 1'($urandom);
         drive_line(int'($urandom_range(1, 8)), 1'b0, 1'b0);
         wait_drain("rand");
         check_stream("rand");
      end

      // Full-length line and a truncated overlong line
      fill_random(800);
      drive_line(2, 1'b0, 1'b0);
      wait_drain("max");
      check_stream("max");
      fill_random(805);
      drive_line(2, 1'b0, 1'b0);
      wait_drain("trunc");
      check_stream("trunc");

      // Line dropped while the emitter is busy
      do_vsync(1'b1);
      fill_random(20);
      drive_line(2, 1'b0, 1'b0);
      fill_random(15);
      drive_line(10, 1'b0, 1'b0);
      wait_drain("drop");
      fill_random(30);
      drive_line(3, 1'b0, 1'b0);
      wait_drain("drop2");
      check_stream("drop");
      chk("drop_cnt1", 64'(drop_count), 64'(m_drops));

      // Rise during the terminator cycle is dropped; one cycle later is accepted
      fill_random(5);
      drive_line(2, 1'b0, 1'b0);
      g = last_len;
      fill_random(5);
      drive_line(g, 1'b0, 1'b0);
      wait_drain("term_a");
      fill_random(6);
      drive_line(2, 1'b0, 1'b0);
      g = last_len + 1;
      fill_random(7);
      drive_line(g, 1'b0, 1'b0);
      wait_drain("term_b");
      check_stream("term");
      chk("drop_cnt2", 64'(drop_count), 64'(m_drops));

      // Unarmed frame produces nothing; rearm resumes at line 0
      do_vsync(1'b0);
      for (int t = 0; t < 3; t++) begin
         fill_random(int'($urandom_range(5, 60)));
         drive_line(3, 1'b0, 1'b0);
      end
      repeat (5) tick();
      check_stream("unarmed");
      chk("unarmed_frame", 64'(frame_num), 64'(m_frame));
      do_vsync(1'b1);
      fill_random(45);
      drive_line(2, 1'b0, 1'b0);
      wait_drain("rearm");
      check_stream("rearm");

      // href fall coincident with vsync rise
      fill_random(10);
      drive_line(2, 1'b1, 1'b1);
      wait_drain("coinc");
      fill_random(12);
      drive_line(2, 1'b0, 1'b0);
      wait_drain("coinc2");
      check_stream("coinc");
      chk("coinc_frame", 64'(frame_num), 64'(m_frame));

      // Asynchronous reset in the middle of the payload
      fill_random(50);
      drive_line(2, 1'b0, 1'b0);
      repeat (30) tick();
      reset_b = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_data", 64'(out_data), 64'd0);
      chk("mid_rst_frame", 64'(frame_num), 64'd0);
      chk("mid_rst_drop", 64'(drop_count), 64'd0);
      obs_w.delete(); obs_c.delete(); exp_w.delete(); exp_c.delete();
      m_frame = 16'd0; m_line = 16'd0; m_armed = 1'b0; m_drops = 0; last_len = 0;
      repeat (2) tick();
      reset_b = 1'b1;
      tick();
      do_vsync(1'b1);
      chk("post_rst_frame", 64'(frame_num), 64'(m_frame));
      fill_random(12);
      drive_line(2, 1'b0, 1'b0);
      wait_drain("post_rst");
      check_stream("post_rst");
      chk("final_drop", 64'(drop_count), 64'(m_drops));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
